// File: rtl/addition_stage4.sv
// Normalization stage of the single-precision FP adder: iterative one-bit-per-cycle
// left normalization; define NORM_FAST_LZC_EN for a single-cycle leading-zero-count shift.
module addition_stage4 #(
    parameter int MENT_WIDTH = 23,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [MENT_WIDTH+1:0] sum_in,
    input  logic [EXP_WIDTH-1:0]  exp_in,
    input  logic                  sign_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [MENT_WIDTH-1:0] mant_out,
    output logic [EXP_WIDTH-1:0]  exp_out,
    output logic                  sign_out,
    output logic                  zero_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);
    localparam int SW = MENT_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SW-1:0]          r_sum, w_sum_nxt;
    logic [EXP_WIDTH-1:0]   r_exp, w_exp_nxt, w_exp_inc;
    logic                   r_sign, r_zero, r_ovf, r_unf;
    logic                   w_zero_nxt, w_ovf_nxt, w_unf_nxt;
    logic                   w_fin;

`ifdef NORM_FAST_LZC_EN
    logic [31:0]            w_lz, w_em1, w_sh;
    logic [SW-1:0]          w_sum_sh;
`endif

    assign w_exp_inc = r_exp + EXP_WIDTH'(1);

`ifdef NORM_FAST_LZC_EN
    // Leading zeros of hidden+fraction; the ascending loop keeps the highest set bit.
    always_comb begin
        w_lz = 32'(MENT_WIDTH + 1);
        for (int i = 0; i <= MENT_WIDTH; i++) begin
            if (r_sum[i]) w_lz = 32'(MENT_WIDTH - i);
        end
        w_em1    = 32'(r_exp) - 32'd1;
        w_sh     = (w_lz < w_em1) ? w_lz : w_em1;
        w_sum_sh = r_sum << w_sh;
    end
`endif

    // One SHIFT evaluation on the working registers; w_fin says whether DONE follows.
    always_comb begin
        w_sum_nxt  = r_sum;
        w_exp_nxt  = r_exp;
        w_zero_nxt = r_zero;
        w_ovf_nxt  = r_ovf;
        w_unf_nxt  = r_unf;
        w_fin      = 1'b1;
        if (r_sum == '0) begin
            w_exp_nxt  = '0;
            w_zero_nxt = 1'b1;
        end else if (r_sum[SW-1]) begin
            w_sum_nxt = r_sum >> 1;
            w_exp_nxt = w_exp_inc;
            if (w_exp_inc == '1) begin
                w_sum_nxt = '0;
                w_ovf_nxt = 1'b1;
            end
        end else if (r_sum[MENT_WIDTH]) begin
            w_fin = 1'b1;
        end else if (r_exp == '0) begin
            w_fin = 1'b1;
`ifdef NORM_FAST_LZC_EN
        end else begin
            w_sum_nxt = w_sum_sh;
            w_exp_nxt = r_exp - w_sh[EXP_WIDTH-1:0];
            if (!w_sum_sh[MENT_WIDTH]) begin
                w_exp_nxt = '0;
                w_unf_nxt = 1'b1;
            end
        end
`else
        end else if (r_exp == EXP_WIDTH'(1)) begin
            w_exp_nxt = '0;
            w_unf_nxt = 1'b1;
        end else begin
            w_sum_nxt = r_sum << 1;
            w_exp_nxt = r_exp - EXP_WIDTH'(1);
            w_fin     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid_in) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_fin)       w_state_nxt = S_DONE;
            S_DONE:  if (out_ready_in) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_out  = (r_state == S_IDLE);
        out_valid_out = (r_state == S_DONE);
        mant_out      = r_sum[MENT_WIDTH-1:0];
        exp_out       = r_exp;
        sign_out      = r_sign;
        zero_out      = r_zero;
        overflow_out  = r_ovf;
        underflow_out = r_unf;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sum  <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid_in) begin
                    r_sum  <= sum_in;
                    r_exp  <= exp_in;
                    r_sign <= sign_in;
                    r_zero <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_unf  <= 1'b0;
                end
                S_SHIFT: begin
                    r_sum  <= w_sum_nxt;
                    r_exp  <= w_exp_nxt;
                    r_zero <= w_zero_nxt;
                    r_ovf  <= w_ovf_nxt;
                    r_unf  <= w_unf_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addition_stage4.sv
// Randomized and directed bench for addition_stage4 against a priority-encoder reference model.
module tb_addition_stage4;
    localparam int MW = 23;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [MW+1:0] sum_in = '0;
    logic [EW-1:0] exp_in = '0;
    logic          sign_in = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [MW-1:0] mant_out;
    logic [EW-1:0] exp_out;
    logic          sign_out, zero_out, ovf_out, unf_out;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    addition_stage4 #(.MENT_WIDTH(MW), .EXP_WIDTH(EW)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .in_valid_in(in_valid), .in_ready_out(in_ready),
        .sum_in(sum_in), .exp_in(exp_in), .sign_in(sign_in),
        .out_valid_out(out_valid), .out_ready_in(out_ready),
        .mant_out(mant_out), .exp_out(exp_out), .sign_out(sign_out),
        .zero_out(zero_out), .overflow_out(ovf_out), .underflow_out(unf_out)
    );

    typedef struct {
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic          z, o, u;
        int            k;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Normalize by locating the leading one directly, then count cycles from the shift distance.
    function automatic res_t model(input logic [MW+1:0] s, input logic [EW-1:0] e);
        res_t r;
        logic [MW+1:0] t;
        int p, l;
        r.mant = s[MW-1:0]; r.exp = e; r.z = 0; r.o = 0; r.u = 0; r.k = 0;
        if (s == 0) begin
            r.mant = 0; r.exp = 0; r.z = 1;
        end else if (s[MW+1]) begin
            r.exp = e + 8'd1;
            r.mant = s[MW:1];
            if (r.exp == 8'hFF) begin r.mant = 0; r.o = 1; end
        end else if (!s[MW] && e != 0) begin
            p = 0;
            for (int i = 0; i <= MW; i++) if (s[i]) p = i;
            l = MW - p;
            if (l < int'(e)) begin
                r.k = l; t = s << l; r.exp = 8'(int'(e) - l);
            end else begin
                r.k = int'(e) - 1; t = s << r.k; r.exp = 0; r.u = 1;
            end
            r.mant = t[MW-1:0];
        end
`ifdef NORM_FAST_LZC_EN
        r.k = 0;
`endif
        return r;
    endfunction

    task automatic run_op(input logic [MW+1:0] s, input logic [EW-1:0] e, input logic sg,
                          input int hold, input string tag);
        res_t m;
        int lat;
        logic [MW-1:0] mh;
        m = model(s, e);
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        sum_in = s; exp_in = e; sign_in = sg; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 200);
        chk({tag, ".lat"}, 32'(lat), 32'(m.k + 1));
        chk({tag, ".mant"}, 32'(mant_out), 32'(m.mant));
        chk({tag, ".exp"}, 32'(exp_out), 32'(m.exp));
        chk({tag, ".flags"}, {28'd0, sign_out, zero_out, ovf_out, unf_out}, {28'd0, sg, m.z, m.o, m.u});
        mh = mant_out;
        for (int i = 0; i < hold; i++) begin
            // Upstream may present new operands while we stall; they must be ignored.
            in_valid = 1'b1; sum_in = 25'h0000003; exp_in = 8'h10;
            @(posedge clk); #1;
            chk({tag, ".hold"}, {22'd0, out_valid, in_ready, mant_out == mh, exp_out},
                {22'd0, 1'b1, 1'b0, 1'b1, m.exp});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".idle"}, {30'd0, in_ready, out_valid}, 32'd2);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [MW+1:0] s;
        logic [EW-1:0] e;
        repeat (3) @(posedge clk);
        #1;
        chk("rst", {22'd0, in_ready, out_valid, mant_out == 0, exp_out == 0,
                    sign_out, zero_out, ovf_out, unf_out}, {22'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0});
        @(negedge clk); rst_n = 1'b1;

        run_op(25'h0800000, 8'h80, 1'b0, 0, "norm");
        run_op(25'h1800001, 8'h80, 1'b1, 0, "carry");
        run_op(25'h0000001, 8'h80, 1'b0, 0, "lsb");
        run_op(25'h0000100, 8'h03, 1'b1, 0, "unf");
        run_op(25'h0000000, 8'h55, 1'b1, 0, "zero");
        run_op(25'h1000000, 8'hFE, 1'b0, 3, "ovf");
        run_op(25'h0000400, 8'h00, 1'b0, 0, "subn");
        run_op(25'h0400000, 8'h01, 1'b0, 1, "exp1");

        // Reset in the middle of a long normalization
        @(negedge clk);
        sum_in = 25'h0000001; exp_in = 8'h80; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("midrst", {22'd0, in_ready, out_valid, mant_out == 0, exp_out == 0,
                       sign_out, zero_out, ovf_out, unf_out}, {22'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0});
        @(negedge clk); rst_n = 1'b1;
        run_op(25'h0000030, 8'h40, 1'b1, 0, "postrst");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: s = 25'($urandom);
                1: s = 25'($urandom) >> $urandom_range(1, 24);
                2: s = {1'b0, 1'b1, 23'($urandom)};
                default: s = 25'($urandom_range(0, 1));
            endcase
            case ($urandom_range(0, 2))
                0: e = 8'($urandom);
                1: e = 8'($urandom_range(0, 5));
                default: e = 8'($urandom_range(250, 255));
            endcase
            run_op(s, e, 1'($urandom), $urandom_range(0, 2), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
